// File: rtl/global_types.sv
// ---------------------------------------------------------------------------
// global_types
// Types and constants shared between the execute stage and the iterative
// multiply/divide unit.
//   muldiv_op_t    : operation code carried on the muldiv_unit op port
//   muldiv_state_t : control states of the multiply/divide sequencer
//   MULDIV_CYCLES  : iterations per operation, one result bit per cycle
// ---------------------------------------------------------------------------
package global_types;

  localparam int MULDIV_CYCLES = 32;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } muldiv_state_t;

endpackage

// File: rtl/d_en_reg.sv
// ---------------------------------------------------------------------------
// d_en_reg
// Plain D register with load enable and asynchronous active-high clear.
// Used for the HI and LO special-purpose registers.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-high clear to zero
//   en_i   : load enable
//   d_i    : data loaded when en_i is high
//   q_o    : register contents
// ---------------------------------------------------------------------------
module d_en_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Hold the stored value unless the owner explicitly loads a new one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit that owns HI and LO. One result bit is
// produced per cycle; the sign fix-up and HI/LO write happen in a final
// cycle. The pipeline reads HI/LO directly and may write them (MTHI/MTLO)
// while the unit is idle.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   start        : request pulse, only looked at while idle
//   op           : muldiv_op_t operation (MULTU, MULT, DIVU, DIV)
//   a, b         : multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we : MTHI / MTLO write enables
//   wd           : MTHI / MTLO write data
//   busy         : high whenever an operation is in progress
//   done         : one-cycle pulse after HI/LO were written with a result
//   hi, lo       : HI and LO register contents
// ---------------------------------------------------------------------------
module muldiv_unit
  import global_types::*;
#(
  parameter int WIDTH = MULDIV_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               isDiv_q, isDiv_d;
  logic               resNeg_q, resNeg_d;
  logic               remNeg_q, remNeg_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   opA_q, opA_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               done_q, done_d;

  muldiv_op_t       opIn;
  logic             reqDiv;
  logic             reqSigned;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH-1:0] aAbs;
  logic [WIDTH-1:0] bAbs;

  logic [WIDTH-1:0] mulAddend;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH+1:0] divShift;
  logic [WIDTH+1:0] divDiff;
  logic             divGeq;

  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  logic             mtOk;
  logic             hiEn;
  logic             loEn;
  logic [WIDTH-1:0] hiD;
  logic [WIDTH-1:0] loD;

  assign opIn = muldiv_op_t'(op);

  // Decode the incoming request. Signed ops work on magnitudes and remember
  // the operand signs so the result can be corrected in the final cycle.
  always_comb begin
    reqDiv    = (opIn == DIVU) || (opIn == DIV);
    reqSigned = (opIn == MULT) || (opIn == DIV);
    aNeg      = reqSigned & a[WIDTH-1];
    bNeg      = reqSigned & b[WIDTH-1];
    aAbs      = aNeg ? -a : a;
    bAbs      = bNeg ? -b : b;
  end

  // Multiply step: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  // Divide step: shift the next dividend bit into the remainder and subtract
  // the divisor if it fits; the borrow bit of the difference decides.
  // opA doubles as dividend shifter and quotient collector during a divide.
  always_comb begin
    mulAddend = opB_q[0] ? opA_q : '0;
    mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
    divShift  = {rem_q, opA_q[WIDTH-1]};
    divDiff   = divShift - {2'b00, opB_q};
    divGeq    = ~divDiff[WIDTH+1];
  end

  // Final sign fix-up. Negation wraps, which is what makes the signed
  // overflow case (most negative / -1) come out as most negative, HI = 0.
  always_comb begin
    prodFix = resNeg_q ? -acc_q : acc_q;
    quotFix = resNeg_q ? -opA_q : opA_q;
    remFix  = remNeg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    if (divZero_q) begin
      resHi = '0;
      resLo = '0;
    end else if (isDiv_q) begin
      resHi = remFix;
      resLo = quotFix;
    end else begin
      resHi = prodFix[2*WIDTH-1:WIDTH];
      resLo = prodFix[WIDTH-1:0];
    end
  end

  // Sequencer and datapath next-state. A divide by zero skips the iterations
  // entirely; everything else runs exactly WIDTH steps before FIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isDiv_d   = isDiv_q;
    resNeg_d  = resNeg_q;
    remNeg_d  = remNeg_q;
    divZero_d = divZero_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          isDiv_d   = reqDiv;
          resNeg_d  = aNeg ^ bNeg;
          remNeg_d  = aNeg;
          divZero_d = reqDiv && (b == '0);
          opA_d     = aAbs;
          opB_d     = bAbs;
          acc_d     = '0;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = (reqDiv && (b == '0)) ? FIN : RUN;
        end
      end
      RUN: begin
        if (isDiv_q) begin
          opA_d = {opA_q[WIDTH-2:0], divGeq};
          rem_d = divGeq ? divDiff[WIDTH:0] : divShift[WIDTH:0];
        end else begin
          acc_d = {mulSum, acc_q[WIDTH-1:1]};
          opB_d = opB_q >> 1;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All sequencer and datapath state; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      resNeg_q  <= 1'b0;
      remNeg_q  <= 1'b0;
      divZero_q <= 1'b0;
      opA_q     <= '0;
      opB_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isDiv_q   <= isDiv_d;
      resNeg_q  <= resNeg_d;
      remNeg_q  <= remNeg_d;
      divZero_q <= divZero_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
    end
  end

  // HI/LO load control. MT writes only land when idle and no start is being
  // accepted in the same cycle; a result write in FIN always wins.
  always_comb begin
    mtOk = (state_q == IDLE) && !start;
    hiEn = (state_q == FIN) || (mtOk && hi_we);
    loEn = (state_q == FIN) || (mtOk && lo_we);
    hiD  = (state_q == FIN) ? resHi : wd;
    loD  = (state_q == FIN) ? resLo : wd;
  end

  d_en_reg #(.WIDTH(WIDTH)) u_hiReg (
    .clock (clock),
    .reset (reset),
    .en_i  (hiEn),
    .d_i   (hiD),
    .q_o   (hi)
  );

  d_en_reg #(.WIDTH(WIDTH)) u_loReg (
    .clock (clock),
    .reset (reset),
    .en_i  (loEn),
    .d_i   (loD),
    .q_o   (lo)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit. Expected HI/LO values come from a small
// behavioural model using wide native arithmetic and are queued when a
// request is driven, then popped and compared when done is seen.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sbQ[$];
  logic [31:0] modelHi = '0;
  logic [31:0] modelLo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  // Safety net so the run always ends even if the design wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference results {HI, LO} computed with native wide arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ux;
    logic [63:0] uy;
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    model = '0;
    case (o)
      2'b00: begin
        ux = {32'b0, x};
        uy = {32'b0, y};
        model = ux * uy;
      end
      2'b01: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p = 64'(sx * sy);
        model = p;
      end
      2'b10: begin
        if (y != 0) model = {x % y, x / y};
      end
      default: begin
        if (y != 0) begin
          sx = longint'($signed(x));
          sy = longint'($signed(y));
          q = sx / sy;
          r = sx % sy;
          model = {r[31:0], q[31:0]};
        end
      end
    endcase
  endfunction

  // One comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // MTHI/MTLO write in one idle cycle; the bench tracks the register model.
  task automatic mtWrite(input bit wh, input bit wl, input logic [31:0] d);
    hi_we = wh;
    lo_we = wl;
    wd    = d;
    @(posedge clock); #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (wh) modelHi = d;
    if (wl) modelLo = d;
  endtask

  // Issue one request from the post-edge sample point, follow it to done and
  // score it. With disturb set, an MT write rides along with the start and a
  // second start plus MT write is pulsed mid-run; all must be ignored.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit disturb, input string tag);
    logic [63:0] expRes;
    int          n;
    int          busyN;
    int          expLat;
    expLat = (o[1] && (y == 0)) ? 1 : 33;
    sbQ.push_back(model(o, x, y));
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (disturb) begin
      hi_we = 1'b1;
      wd    = 32'h0000_0BAD;
    end
    @(posedge clock); #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
    n     = 0;
    busyN = (busy === 1'b1) ? 1 : 0;
    checkOutput({tag, "_busyStart"}, 64'(busy), 64'(1));
    checkOutput({tag, "_doneLow"}, 64'(done), 64'(0));
    while (done !== 1'b1 && n < 100) begin
      if (disturb && n == 5) begin
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd9;
        b     = 32'd3;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wd    = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
      @(posedge clock); #1;
      n++;
      if (n == 10) checkOutput({tag, "_holdHiLo"}, {hi, lo}, {modelHi, modelLo});
      if (busy === 1'b1) busyN++;
    end
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput({tag, "_latency"}, 64'(n), 64'(expLat));
    checkOutput({tag, "_busyCycles"}, 64'(busyN), 64'(expLat));
    checkOutput({tag, "_busyAtDone"}, 64'(busy), 64'(0));
    expRes = (sbQ.size() > 0) ? sbQ.pop_front() : 'x;
    checkOutput({tag, "_hiLo"}, {hi, lo}, expRes);
    modelHi = expRes[63:32];
    modelLo = expRes[31:0];
  endtask

  // Directed sequence: reset, MT preload, handshake abuse, test-plan vectors
  // back to back, random vectors, dual MT write, reset mid-run, recovery.
  initial begin
    bit sawDone;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wd    = '0;
    #8;
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_hi", 64'(hi), 64'(0));
    checkOutput("reset_lo", 64'(lo), 64'(0));
    #2;
    reset = 1'b0;
    @(posedge clock); #1;

    mtWrite(1'b1, 1'b0, 32'h0000_1234);
    mtWrite(1'b0, 1'b1, 32'h0000_5678);
    checkOutput("mt_readback", {hi, lo}, {modelHi, modelLo});

    applyStimulus(2'b00, 32'd3, 32'd4, 1'b1, "handshake_multu");

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
    applyStimulus(2'b10, 32'd7, 32'd2, 1'b0, "divu_7_2");
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7_2");
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    applyStimulus(2'b10, 32'd5, 32'd0, 1'b0, "divu_zero");
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
    applyStimulus(2'b11, 32'd100, 32'hFFFF_FFF9, 1'b0, "div_pos_neg");

    for (int i = 0; i < 6; i++) begin
      logic [1:0]  ro;
      logic [31:0] rx;
      logic [31:0] ry;
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 31);
      applyStimulus(ro, rx, ry, 1'b0, $sformatf("rand%0d", i));
    end

    mtWrite(1'b1, 1'b1, 32'h0000_CAFE);
    checkOutput("mt_both", {hi, lo}, {modelHi, modelLo});

    start = 1'b1;
    op    = 2'b01;
    a     = 32'h1234_5678;
    b     = 32'hFEDC_BA98;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    #1;
    modelHi = '0;
    modelLo = '0;
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_done", 64'(done), 64'(0));
    checkOutput("midreset_hiLo", {hi, lo}, {modelHi, modelLo});
    @(negedge clock);
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("midreset_noDone", 64'(sawDone), 64'(0));
    checkOutput("midreset_hiLoAfter", {hi, lo}, {modelHi, modelLo});

    applyStimulus(2'b10, 32'd100, 32'd7, 1'b0, "recover_divu");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
